// File: rtl/mem_pkg.sv
// Shared state encoding and default geometry for the MAR/MDR memory responder.
package mem_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 512;
  localparam int DEF_WAIT   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath (master) and mem_responder (slave).
// Err is only present when MEM_RANGE_CHECK_EN is defined.
interface mem_responder_if;

  logic        Read;
  logic        Write;
  logic [31:0] MAR;
  logic [31:0] MDRout;
  logic [31:0] Mdatain;
  logic        Done;
  logic        Busy;
`ifdef MEM_RANGE_CHECK_EN
  logic        Err;
`endif

  modport master (
    output Read, Write, MAR, MDRout,
    input  Mdatain, Done, Busy
`ifdef MEM_RANGE_CHECK_EN
    , input Err
`endif
  );

  modport slave (
    input  Read, Write, MAR, MDRout,
    output Mdatain, Done, Busy
`ifdef MEM_RANGE_CHECK_EN
    , output Err
`endif
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x 32, registered read, contents never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a Read/Write request, waits WAIT cycles, accesses
// the RAM and completes with a four-phase Done handshake. Optional MEM_RANGE_CHECK_EN adds Err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WAIT   = DEF_WAIT
) (
  input logic            clk,
  input logic            clr,
  mem_responder_if.slave bus
);

  state_t            state, state_n;
  logic [3:0]        wait_cnt, wait_cnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ram_rdata;
  logic [31:0]       mdata_q;
  logic              is_write_q;
  logic              done_q;
  logic              oor_q;
  logic              req;
  logic              ram_we;
  logic              ram_re;

  assign req = bus.Read | bus.Write;

  // The WAIT parameter shadows the enum literal, so the state is named through the package.
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT > 0) begin
            state_n    = mem_pkg::WAIT;
            wait_cnt_n = 4'(WAIT - 1);
          end else begin
            state_n = ACCESS;
          end
        end
      end
      mem_pkg::WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_n = ACCESS;
        end else begin
          wait_cnt_n = wait_cnt - 4'd1;
        end
      end
      ACCESS: state_n = DONE;
      DONE: begin
        if (done_q && !req) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Done rises one edge after DONE is entered so the registered read data lines up with it.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      done_q   <= 1'b0;
      mdata_q  <= 32'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      done_q   <= (state == DONE) && (state_n == DONE);
      if (state == DONE && !done_q && !is_write_q) begin
        mdata_q <= oor_q ? 32'd0 : ram_rdata;
      end
    end
  end

  // Simultaneous Read and Write is serviced as a read.
  always_ff @(posedge clk) begin
    if (clr) begin
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      is_write_q <= 1'b0;
    end else if (state == IDLE && req) begin
      addr_q     <= bus.MAR[ADDR_W-1:0];
      wdata_q    <= bus.MDRout;
      is_write_q <= bus.Write & ~bus.Read;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      oor_q <= 1'b0;
    end else if (state == IDLE && req) begin
      oor_q <= (bus.MAR >= 32'(DEPTH));
    end
  end

  assign bus.Err = done_q & oor_q;
`else
  logic unused_mar_hi;

  assign oor_q         = 1'b0;
  assign unused_mar_hi = ^bus.MAR[31:ADDR_W];
`endif

  // Gating with clr keeps a reset on the ACCESS edge from committing the write.
  assign ram_we = (state == ACCESS) && is_write_q && !oor_q && !clr;
  assign ram_re = (state == ACCESS) && !is_write_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.Mdatain = mdata_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance with WAIT=2, one with WAIT=0.
module tb_mem_responder;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT(2)) dut_a (
    .clk (clk),
    .clr (clr),
    .bus (bus_a)
  );

  mem_responder #(.ADDR_W(9), .DEPTH(512), .WAIT(0)) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit b, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
    if (b) begin
      bus_b.Read = rd; bus_b.Write = wr; bus_b.MAR = addr; bus_b.MDRout = data;
    end else begin
      bus_a.Read = rd; bus_a.Write = wr; bus_a.MAR = addr; bus_a.MDRout = data;
    end
  endtask

  function automatic logic get_done(input bit b);
    return b ? bus_b.Done : bus_a.Done;
  endfunction

  function automatic logic get_busy(input bit b);
    return b ? bus_b.Busy : bus_a.Busy;
  endfunction

  function automatic logic [31:0] get_mdata(input bit b);
    return b ? bus_b.Mdatain : bus_a.Mdatain;
  endfunction

  // Raise the strobes and wait (bounded) for Done; strobes stay high on return.
  task automatic apply_stimulus(input bit b, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data,
                                output int lat, output int busy_cycles);
    lat         = -1;
    busy_cycles = 0;
    set_req(b, rd, wr, addr, data);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (get_done(b)) begin
        lat = i - 1;
        break;
      end
      if (get_busy(b)) busy_cycles++;
    end
  endtask

  task automatic release_req(input bit b, input string tag);
    set_req(b, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check_output({tag, "_done_fall"}, 32'(get_done(b)), 32'd0);
  endtask

  task automatic write_word(input bit b, input logic [31:0] addr, input logic [31:0] data,
                            input string tag);
    int lat, bc;
    apply_stimulus(b, 1'b0, 1'b1, addr, data, lat, bc);
    check_output({tag, "_lat"}, 32'(lat), b ? 32'd2 : 32'd4);
    release_req(b, tag);
  endtask

  task automatic read_word(input bit b, input logic [31:0] addr, input logic [31:0] exp,
                           input string tag);
    int lat, bc;
    apply_stimulus(b, 1'b1, 1'b0, addr, 32'd0, lat, bc);
    check_output({tag, "_lat"}, 32'(lat), b ? 32'd2 : 32'd4);
    check_output({tag, "_data"}, get_mdata(b), exp);
    release_req(b, tag);
  endtask

  initial begin
    int lat, bc, done_cnt;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    check_output("rst_done", 32'(bus_a.Done), 32'd0);
    check_output("rst_busy", 32'(bus_a.Busy), 32'd0);
    check_output("rst_mdata", bus_a.Mdatain, 32'd0);
    repeat (3) tick();
    check_output("idle_busy", 32'(bus_a.Busy), 32'd0);
    check_output("idle_done", 32'(bus_a.Done), 32'd0);

    write_word(1'b0, 32'd5, 32'hDEADBEEF, "wr5");
    check_output("wr_keeps_mdata", bus_a.Mdatain, 32'd0);
    read_word(1'b0, 32'd5, 32'hDEADBEEF, "rd5");

    // Read and Write together: the read wins and address 7 keeps 0x11.
    write_word(1'b0, 32'd7, 32'h00000011, "wr7");
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'd7, 32'h00000099, lat, bc);
    check_output("both_lat", 32'(lat), 32'd4);
    check_output("both_data", bus_a.Mdatain, 32'h00000011);
    release_req(1'b0, "both");
    read_word(1'b0, 32'd7, 32'h00000011, "rd7");

    // Write strobe dropped right after being sampled.
    set_req(1'b0, 1'b0, 1'b1, 32'd20, 32'hCAFEF00D);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_a.Done) done_cnt++;
    end
    check_output("early_done_pulse", 32'(done_cnt), 32'd1);
    check_output("early_busy", 32'(bus_a.Busy), 32'd0);
    check_output("early_mdata", bus_a.Mdatain, 32'h00000011);
    read_word(1'b0, 32'd20, 32'hCAFEF00D, "rd20");

    // Reset while a write to address 9 sits in WAIT.
    write_word(1'b0, 32'd9, 32'h00005555, "wr9");
    set_req(1'b0, 1'b0, 1'b1, 32'd9, 32'h00001234);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_output("midrst_busy", 32'(bus_a.Busy), 32'd0);
    check_output("midrst_mdata", bus_a.Mdatain, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_a.Done) done_cnt++;
    end
    check_output("midrst_no_done", 32'(done_cnt), 32'd0);
    read_word(1'b0, 32'd9, 32'h00005555, "rd9");

    write_word(1'b0, 32'd88, 32'h00000088, "wr88");
`ifdef MEM_RANGE_CHECK_EN
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'd600, 32'hA5A5A5A5, lat, bc);
    check_output("oor_wr_lat", 32'(lat), 32'd4);
    check_output("oor_wr_err", 32'(bus_a.Err), 32'd1);
    release_req(1'b0, "oor_wr");
    check_output("oor_err_fall", 32'(bus_a.Err), 32'd0);
    read_word(1'b0, 32'd88, 32'h00000088, "rd88");
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd600, 32'd0, lat, bc);
    check_output("oor_rd_data", bus_a.Mdatain, 32'd0);
    check_output("oor_rd_err", 32'(bus_a.Err), 32'd1);
    release_req(1'b0, "oor_rd");
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, lat, bc);
    check_output("inrange_err", 32'(bus_a.Err), 32'd0);
    release_req(1'b0, "inrange");
`else
    write_word(1'b0, 32'd600, 32'hA5A5A5A5, "wr600");
    read_word(1'b0, 32'd88, 32'hA5A5A5A5, "wrap88");
`endif

    // Zero wait states on the second instance.
    write_word(1'b1, 32'd0, 32'h0BADCAFE, "b_wr0");
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, lat, bc);
    check_output("b_rd_lat", 32'(lat), 32'd2);
    check_output("b_rd_busy", 32'(bc), 32'd2);
    check_output("b_rd_data", bus_b.Mdatain, 32'h0BADCAFE);
    release_req(1'b1, "b_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
